// File: rtl/nes_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nes_mem_arbiter
// Purpose  : Shares one memory port between the 6502 core and the host loader
//            using fixed three-cycle transactions. Grant counters: ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
module nes_mem_arbiter #(
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 8,
   parameter int HOST_MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_run,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_write,
   input  logic [DATA_W-1:0] cpu_dout,
   output logic [DATA_W-1:0] cpu_din,
   output logic              cpu_ready,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_in,
   input  logic [DATA_W-1:0] mem_out,
   output logic [15:0]       stat_cpu_grants,
   output logic [15:0]       stat_host_grants
);

   localparam logic [7:0] c_max_wait = 8'(HOST_MAX_WAIT);

   typedef enum logic [1:0] {
      ST_ARB    = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_write;
   logic [DATA_W-1:0] r_mem_in;
   logic              r_xact_host;
   logic              r_xact_we;
   logic [7:0]        r_wait_cnt;
   logic [DATA_W-1:0] r_cpu_din;
   logic [DATA_W-1:0] r_host_rdata;
   logic              w_force_host;
   logic              w_host_win;
   logic              w_cpu_win;

   always_comb begin
      w_state_nxt  = r_state;
      w_force_host = host_req && (r_wait_cnt == c_max_wait);
      w_host_win   = 1'b0;
      w_cpu_win    = 1'b0;
      cpu_ready    = 1'b0;
      host_ack     = 1'b0;
      cpu_din      = r_cpu_din;
      host_rdata   = r_host_rdata;
      unique case (r_state)
         ST_ARB: begin
            w_host_win = host_req && (w_force_host || !cpu_run);
            w_cpu_win  = cpu_run && !w_force_host;
            if (w_host_win || w_cpu_win) begin
               w_state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: w_state_nxt = ST_DONE;
         ST_DONE: begin
            w_state_nxt = ST_ARB;
            // Read data is forwarded in the completion cycle and then held.
            if (r_xact_host) begin
               host_ack = 1'b1;
               if (!r_xact_we) begin
                  host_rdata = mem_out;
               end
            end else begin
               cpu_ready = 1'b1;
               cpu_din   = mem_out;
            end
         end
         default: w_state_nxt = ST_ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_ARB;
         r_mem_addr   <= '0;
         r_mem_write  <= 1'b0;
         r_mem_in     <= '0;
         r_xact_host  <= 1'b0;
         r_xact_we    <= 1'b0;
         r_wait_cnt   <= '0;
         r_cpu_din    <= '0;
         r_host_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_mem_write <= 1'b0;
         if (w_cpu_win) begin
            r_mem_addr  <= cpu_addr;
            r_mem_write <= cpu_write;
            r_mem_in    <= cpu_dout;
            r_xact_host <= 1'b0;
            r_xact_we   <= cpu_write;
         end else if (w_host_win) begin
            r_mem_addr  <= host_addr;
            r_mem_write <= host_we;
            r_mem_in    <= host_wdata;
            r_xact_host <= 1'b1;
            r_xact_we   <= host_we;
         end
         if (r_state == ST_ARB) begin
            if (w_host_win || !host_req) begin
               r_wait_cnt <= '0;
            end else if (r_wait_cnt < c_max_wait) begin
               r_wait_cnt <= r_wait_cnt + 8'd1;
            end
         end
         if (r_state == ST_DONE) begin
            if (!r_xact_host) begin
               r_cpu_din <= mem_out;
            end else if (!r_xact_we) begin
               r_host_rdata <= mem_out;
            end
         end
      end
   end

   assign mem_addr  = r_mem_addr;
   assign mem_write = r_mem_write;
   assign mem_in    = r_mem_in;

`ifdef ARB_STATS_EN
   logic [15:0] r_stat_cpu;
   logic [15:0] r_stat_host;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_cpu  <= '0;
         r_stat_host <= '0;
      end else if (r_state == ST_DONE) begin
         if (r_xact_host) begin
            if (r_stat_host != 16'hFFFF) begin
               r_stat_host <= r_stat_host + 16'd1;
            end
         end else begin
            if (r_stat_cpu != 16'hFFFF) begin
               r_stat_cpu <= r_stat_cpu + 16'd1;
            end
         end
      end
   end

   assign stat_cpu_grants  = r_stat_cpu;
   assign stat_host_grants = r_stat_host;
`else
   assign stat_cpu_grants  = 16'd0;
   assign stat_host_grants = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/nes_mem_arbiter.md
Name: nes_mem_arbiter

Overview:
- Shares the single-port program/data memory between the 6502 CPU core and the host loader port, which is driven by the Avalon slave write/read path.
- Sequences every memory access as a fixed three-cycle transaction and stalls the CPU through its ready input.
- Guarantees host forward progress while the CPU runs, using a starvation counter.
- Sits between the nes top-level, the cpu instance and the memory instance.

Parameters:
- ADDR_W, 16, memory/CPU address width.
- DATA_W, 8, memory data width.
- HOST_MAX_WAIT, 8, cycles a pending host request may lose arbitration before it is forced through (legal range 1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_run  in  1  1 = CPU may be granted; 0 = CPU frozen, host only.
- cpu_addr  in  ADDR_W  CPU address; held stable while cpu_ready=0.
- cpu_write  in  1  CPU write strobe.
- cpu_dout  in  DATA_W  CPU write data.
- cpu_din  out  DATA_W  read data to CPU.
- cpu_ready  out  1  one-cycle advance pulse to CPU.
- host_req  in  1  host access request (level).
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_rdata  out  DATA_W  host read data.
- host_ack  out  1  one-cycle completion pulse.
- mem_addr  out  ADDR_W  memory address (registered).
- mem_write  out  1  memory write enable (registered).
- mem_in  out  DATA_W  memory write data (registered).
- mem_out  in  DATA_W  memory read data, valid one cycle after address.
- stat_cpu_grants  out  16  CPU grant count (feature only).
- stat_host_grants  out  16  host grant count (feature only).

Behaviour:
- CPU request = cpu_run. The CPU accesses memory every cycle. There is no separate CPU request line.
- FSM states and transitions:
  - ARB: sample requests and pick a winner. Latch the winner's addr/we/wdata into mem_addr/mem_write/mem_in, then go to ACCESS. With no requester, stay in ARB with mem_write=0.
  - ACCESS: memory sees the registered address/write this cycle. Go to DONE.
  - DONE: mem_write=0.
    - CPU grant: cpu_din<=mem_out, cpu_ready=1 for this single cycle.
    - Host grant: host_rdata<=mem_out on reads (unchanged on writes), host_ack=1 for this single cycle.
    - Go to ARB.
- Latency: request seen in ARB, ack/ready in DONE = ARB+2. Throughput is one access per 3 cycles.
- Write timing: mem_write is 1 only during ACCESS, for exactly one cycle per write.
- Arbitration in ARB, in priority order:
  - host_req && wait_cnt==HOST_MAX_WAIT -> host.
  - cpu_run -> CPU.
  - host_req -> host.
- wait_cnt (8 bit):
  - Increments in ARB when host_req=1 and the CPU wins.
  - Saturates at HOST_MAX_WAIT.
  - Clears on host grant and whenever host_req=0 in ARB.
- Host handshake:
  - Fields are sampled only in ARB and must be held from req assertion to ack.
  - If req is still 1 in the ARB cycle after ack, that is a new request using the current fields.
- cpu_run falling:
  - During ACCESS/DONE of a CPU transaction, the transaction completes and cpu_ready still pulses.
  - From the next ARB on, the CPU is not granted and cpu_ready stays 0.
- cpu_ready is 0 in every cycle except a CPU DONE.
- Reset (any state, including mid-transaction):
  - Next state ARB.
  - Outputs: mem_write=0, mem_addr=0, mem_in=0, cpu_ready=0, host_ack=0, cpu_din=0, host_rdata=0, wait_cnt=0.
  - An interrupted write is never issued after reset.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - stat_cpu_grants and stat_host_grants increment by 1 in each DONE of the respective grant.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: both ports tie to 0 and no counter flops are built.

Test Plan:
- Host write only:
  - Stimulus: cpu_run=0, host write addr 16'h0010, data 8'hA9.
  - Response: mem_write=1 for one cycle with mem_addr=16'h0010 and mem_in=8'hA9. host_ack arrives 2 cycles after the ARB sample. cpu_ready stays 0 throughout.
- Host readback:
  - Stimulus: host read of 16'h0010 after the write above.
  - Response: host_rdata=8'hA9 in the host_ack cycle.
- CPU run:
  - Stimulus: preload 16'h0000..2 = A9 05 00, cpu_run=1, CPU reads 16'h0000.
  - Response: cpu_ready pulses every 3rd cycle. cpu_din=8'hA9 on the first pulse.
- Host starvation:
  - Stimulus: cpu_run=1 continuous, host_req held, HOST_MAX_WAIT=8.
  - Response: the host is granted on the ARB where wait_cnt==8, i.e. after exactly 8 CPU transactions. wait_cnt then clears.
- Reset mid-write:
  - Stimulus: reset asserted in the ACCESS cycle of a host write.
  - Response: next cycle mem_write=0, host_ack=0, FSM in ARB. No ack is ever produced for that write.
- Stats (ARB_STATS_EN):
  - Stimulus: 5 CPU and 2 host transactions.
  - Response: stat_cpu_grants=5, stat_host_grants=2.
